// File: rtl/histogram_accum_if.sv
// rtl/histogram_accum_if.sv - histogram readout stream (valid/ready beats of bin, count, last)
interface histogram_accum_if #(
  parameter int PIX_W   = 10,
  parameter int COUNT_W = 24
);
  logic               hist_valid;
  logic               hist_ready;
  logic [PIX_W-1:0]   hist_bin;
  logic [COUNT_W-1:0] hist_count;
  logic               hist_last;

  modport master (output hist_valid, hist_bin, hist_count, hist_last, input hist_ready);
  modport slave  (input hist_valid, hist_bin, hist_count, hist_last, output hist_ready);
endinterface

// File: rtl/histogram_accum.sv
// rtl/histogram_accum.sv - per-frame pixel histogram in one RAM, streamed out and cleared on readout
module histogram_accum #(
  parameter int PIX_W   = 10,
  parameter int COUNT_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_valid,
  input  logic               line_valid,
  input  logic [PIX_W-1:0]   pixel_data,
  output logic               busy,
  output logic               drop_flag,
  histogram_accum_if.master  hist
);
  localparam int NBINS = 1 << PIX_W;

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_ACCUM, S_DRAIN, S_READOUT} state_t;

  state_t             state;
  logic               fv_q;
  logic [PIX_W-1:0]   clr_idx;
  logic [PIX_W-1:0]   rd_idx;
  logic               drain_cnt;
  logic               rd_pend;
  logic               s1_valid;
  logic [PIX_W-1:0]   s1_bin;
  logic               fw_valid;
  logic [PIX_W-1:0]   fw_bin;
  logic [COUNT_W-1:0] fw_data;

  logic [COUNT_W-1:0] mem [NBINS];
  logic [COUNT_W-1:0] rd_q;

  logic               fv_rise, fv_fall, pix, accept, handshake, we;
  logic [PIX_W-1:0]   waddr, raddr;
  logic [COUNT_W-1:0] base, inc, wdata;

  assign fv_rise   = frame_valid & ~fv_q;
  assign fv_fall   = ~frame_valid & fv_q;
  assign pix       = frame_valid & line_valid;
  assign accept    = pix && (state == S_ACCUM || (state == S_IDLE && fv_rise));
  assign handshake = hist.hist_valid & hist.hist_ready;
  assign busy      = (state == S_CLEAR) || (state == S_DRAIN) || (state == S_READOUT);

  // The RAM read for s1 launched on the same edge as the previous write, so it missed that update
  assign base = (fw_valid && fw_bin == s1_bin) ? fw_data : rd_q;
  assign inc  = (&base) ? base : base + 1'b1;

  always_comb begin
    we    = 1'b0;
    waddr = s1_bin;
    wdata = inc;
    raddr = pixel_data;
    if (state == S_CLEAR) begin
      we    = 1'b1;
      waddr = clr_idx;
      wdata = '0;
    end else if (state == S_READOUT) begin
      raddr = handshake ? rd_idx + 1'b1 : rd_idx;
      if (rd_pend) begin
        we    = 1'b1;
        waddr = rd_idx;
        wdata = '0;
      end
    end else if (s1_valid) begin
      we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rd_q <= mem[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_CLEAR;
      fv_q            <= 1'b0;
      clr_idx         <= '0;
      rd_idx          <= '0;
      drain_cnt       <= 1'b0;
      rd_pend         <= 1'b0;
      s1_valid        <= 1'b0;
      s1_bin          <= '0;
      fw_valid        <= 1'b0;
      fw_bin          <= '0;
      fw_data         <= '0;
      drop_flag       <= 1'b0;
      hist.hist_valid <= 1'b0;
      hist.hist_bin   <= '0;
      hist.hist_count <= '0;
      hist.hist_last  <= 1'b0;
    end else begin
      fv_q     <= frame_valid;
      s1_valid <= accept;
      s1_bin   <= pixel_data;
      fw_valid <= s1_valid;
      fw_bin   <= s1_bin;
      fw_data  <= inc;
      if ((pix && busy) || (fv_rise && state != S_IDLE)) drop_flag <= 1'b1;

      case (state)
        S_CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (&clr_idx) state <= S_IDLE;
        end
        S_IDLE: begin
          if (fv_rise) state <= S_ACCUM;
        end
        S_ACCUM: begin
          if (fv_fall) begin
            state     <= S_DRAIN;
            drain_cnt <= 1'b0;
          end
        end
        S_DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) begin
            state   <= S_READOUT;
            rd_idx  <= '0;
            rd_pend <= 1'b0;
          end
        end
        S_READOUT: begin
          if (rd_pend) begin
            hist.hist_valid <= 1'b1;
            hist.hist_bin   <= rd_idx;
            hist.hist_count <= rd_q;
            hist.hist_last  <= &rd_idx;
            rd_pend         <= 1'b0;
          end else if (handshake) begin
            hist.hist_valid <= 1'b0;
            if (hist.hist_last) begin
              hist.hist_last <= 1'b0;
              state          <= S_IDLE;
            end else begin
              rd_idx  <= rd_idx + 1'b1;
              rd_pend <= 1'b1;
            end
          end else if (!hist.hist_valid) begin
            rd_pend <= 1'b1;
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_histogram_accum.sv
// tb/tb_histogram_accum.sv - bench for histogram_accum (wide and 4-bit-count instances in lockstep)
module tb_histogram_accum;
  typedef struct {
    int bin;
    int cnt;
    bit last;
  } beat_t;

  typedef struct {
    string name;
    int    px[6];
    int    rep;
    int    bin_a, exp_a, sat_a;
    int    bin_b, exp_b, sat_b;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       fv, lv;
  logic [9:0] pixel;
  logic       hist_ready;
  logic       busy_m, drop_m, busy_s, drop_s;

  int    checks = 0;
  int    errors = 0;
  beat_t q_m[$];
  beat_t q_s[$];
  vec_t  vecs[7];

  histogram_accum_if #(.PIX_W(10), .COUNT_W(24)) hm ();
  histogram_accum_if #(.PIX_W(10), .COUNT_W(4))  hs ();
  assign hm.hist_ready = hist_ready;
  assign hs.hist_ready = hist_ready;

  histogram_accum #(.PIX_W(10), .COUNT_W(24)) dut_m (
    .clk(clk), .rst_n(rst_n), .frame_valid(fv), .line_valid(lv), .pixel_data(pixel),
    .busy(busy_m), .drop_flag(drop_m), .hist(hm.master));

  histogram_accum #(.PIX_W(10), .COUNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .frame_valid(fv), .line_valid(lv), .pixel_data(pixel),
    .busy(busy_s), .drop_flag(drop_s), .hist(hs.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (rst_n && hm.hist_valid && hm.hist_ready) begin
      checks++;
      if (q_m.size() == 0) begin
        errors++;
        $display("FAIL beat_main unexpected bin=%0d cnt=%0d", hm.hist_bin, hm.hist_count);
      end else begin
        e = q_m.pop_front();
        if ({hm.hist_bin, hm.hist_count, hm.hist_last} !== {10'(e.bin), 24'(e.cnt), e.last}) begin
          errors++;
          $display("FAIL beat_main got bin=%0d cnt=%0d last=%0d want bin=%0d cnt=%0d last=%0d",
                   hm.hist_bin, hm.hist_count, hm.hist_last, e.bin, e.cnt, e.last);
        end
      end
    end
    if (rst_n && hs.hist_valid && hs.hist_ready) begin
      checks++;
      if (q_s.size() == 0) begin
        errors++;
        $display("FAIL beat_sat unexpected bin=%0d cnt=%0d", hs.hist_bin, hs.hist_count);
      end else begin
        e = q_s.pop_front();
        if ({hs.hist_bin, hs.hist_count, hs.hist_last} !== {10'(e.bin), 4'(e.cnt), e.last}) begin
          errors++;
          $display("FAIL beat_sat got bin=%0d cnt=%0d last=%0d want bin=%0d cnt=%0d last=%0d",
                   hs.hist_bin, hs.hist_count, hs.hist_last, e.bin, e.cnt, e.last);
        end
      end
    end
  end

  task automatic push_expect(input int ba, input int ea, input int sa,
                             input int bb, input int eb, input int sb);
    beat_t e;
    for (int b = 0; b < 1024; b++) begin
      e.bin  = b;
      e.last = (b == 1023);
      e.cnt  = (b == ba) ? ea : (b == bb) ? eb : 0;
      q_m.push_back(e);
      e.cnt  = (b == ba) ? sa : (b == bb) ? sb : 0;
      q_s.push_back(e);
    end
  endtask

  task automatic reset_and_clear(input string tag);
    int n;
    rst_n = 1'b0;
    #1;
    check({tag, "_rst_outs_m"}, {hm.hist_valid, hm.hist_bin, hm.hist_count, hm.hist_last, drop_m, busy_m},
          {1'b0, 10'd0, 24'd0, 1'b0, 1'b0, 1'b1});
    check({tag, "_rst_outs_s"}, {hs.hist_valid, hs.hist_bin, hs.hist_count, hs.hist_last, drop_s, busy_s},
          {1'b0, 10'd0, 4'd0, 1'b0, 1'b0, 1'b1});
    fv = 1'b0;
    lv = 1'b0;
    step;
    rst_n = 1'b1;
    n = 0;
    while (busy_m && n < 3000) begin
      step;
      n++;
    end
    check({tag, "_clear_cycles"}, n, 1024);
    check({tag, "_idle_after_clear"}, {busy_m, busy_s, hm.hist_valid, hs.hist_valid}, 4'b0);
  endtask

  task automatic wait_readout(input string tag, input int stall_bin, input int stall_cnt);
    int n;
    bit stalled, ok;
    n = 0;
    stalled = 1'b0;
    while ((q_m.size() != 0 || q_s.size() != 0) && n < 5000) begin
      step;
      n++;
      if (stall_bin >= 0 && !stalled && hm.hist_valid && int'(hm.hist_bin) == stall_bin) begin
        hist_ready = 1'b0;
        ok = 1'b1;
        repeat (10) begin
          step;
          n++;
          if (!(hm.hist_valid === 1'b1 && int'(hm.hist_bin) == stall_bin &&
                int'(hm.hist_count) == stall_cnt && hm.hist_last === 1'b0)) ok = 1'b0;
        end
        check({tag, "_stall_hold"}, ok, 1);
        hist_ready = 1'b1;
        stalled = 1'b1;
      end
    end
    check({tag, "_readout_done"}, (q_m.size() == 0 && q_s.size() == 0), 1);
    q_m.delete();
    q_s.delete();
    if (stall_bin >= 0) check({tag, "_stall_seen"}, stalled, 1);
    check({tag, "_end_idle"}, {hm.hist_valid, busy_m, hs.hist_valid, busy_s}, 4'b0);
  endtask

  task automatic frame_run(input int v, input int n);
    fv = 1'b1;
    step;
    lv = 1'b1;
    pixel = 10'(v);
    repeat (n) step;
    lv = 1'b0;
    step;
    fv = 1'b0;
    step;
  endtask

  task automatic run_vec(input vec_t v);
    fv = 1'b1;
    lv = 1'b0;
    step;
    for (int r = 0; r < v.rep; r++) begin
      for (int k = 0; k < 6; k++) begin
        if (v.px[k] == -2) break;
        if (v.px[k] == -1) begin
          lv = 1'b0;
        end else begin
          lv = 1'b1;
          pixel = 10'(v.px[k]);
        end
        step;
      end
    end
    lv = 1'b0;
    step;
    fv = 1'b0;
    step;
  endtask

  initial begin
    int n;
    vecs[0] = '{"run5",        '{5, -2, -2, -2, -2, -2},     16, 5,   16, 15, 6,    0, 0};
    vecs[1] = '{"mix78",       '{7, 7, -1, 8, 7, -2},         1, 7,    3,  3, 8,    1, 1};
    vecs[2] = '{"mix78_again", '{7, 7, -1, 8, 7, -2},         1, 7,    3,  3, 8,    1, 1};
    vecs[3] = '{"sat3",        '{3, -2, -2, -2, -2, -2},     20, 3,   20, 15, 4,    0, 0};
    vecs[4] = '{"alt",         '{9, 10, 9, 10, -2, -2},       3, 9,    6,  6, 10,   6, 6};
    vecs[5] = '{"edge",        '{0, 1023, 1023, 0, -2, -2},   2, 0,    4,  4, 1023, 4, 4};
    vecs[6] = '{"gaps",        '{200, -1, 200, -1, 200, -2},  2, 200,  6,  6, 201,  0, 0};

    rst_n = 1'b0;
    fv = 1'b0;
    lv = 1'b0;
    pixel = '0;
    hist_ready = 1'b1;
    #3;
    reset_and_clear("init");

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i]);
      push_expect(vecs[i].bin_a, vecs[i].exp_a, vecs[i].sat_a,
                  vecs[i].bin_b, vecs[i].exp_b, vecs[i].sat_b);
      wait_readout(vecs[i].name, -1, 0);
      check({vecs[i].name, "_drop"}, {drop_m, drop_s}, 2'b00);
    end

    // Backpressure on bin 100
    fv = 1'b1;
    step;
    lv = 1'b1;
    pixel = 10'd100;
    repeat (2) step;
    lv = 1'b0;
    step;
    lv = 1'b1;
    pixel = 10'd101;
    step;
    lv = 1'b0;
    step;
    fv = 1'b0;
    step;
    push_expect(100, 2, 2, 101, 1, 1);
    wait_readout("stall", 100, 2);

    // Frame starting during readout is dropped in full
    frame_run(20, 4);
    push_expect(20, 4, 4, 50, 0, 0);
    n = 0;
    while (!hm.hist_valid && n < 100) begin
      step;
      n++;
    end
    check("drop_readout_started", hm.hist_valid, 1'b1);
    fv = 1'b1;
    step;
    lv = 1'b1;
    pixel = 10'd50;
    repeat (3) step;
    lv = 1'b0;
    check("drop_set_in_readout", {drop_m, drop_s}, 2'b11);
    wait_readout("drop_a", -1, 0);
    lv = 1'b1;
    repeat (3) step;
    lv = 1'b0;
    fv = 1'b0;
    step;
    check("ignored_frame_idle", {busy_m, hm.hist_valid}, 2'b00);
    frame_run(60, 3);
    push_expect(60, 3, 3, 50, 0, 0);
    wait_readout("drop_b", -1, 0);
    check("drop_sticky", {drop_m, drop_s}, 2'b11);

    // Reset in the middle of accumulation discards the partial frame
    fv = 1'b1;
    step;
    lv = 1'b1;
    pixel = 10'd30;
    repeat (5) step;
    #3;
    reset_and_clear("midreset");
    frame_run(30, 2);
    push_expect(30, 2, 2, 31, 0, 0);
    wait_readout("after_reset", -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
